// File: rtl/request_dispatcher.sv
// Pops the granted queue head into a 2-entry output buffer and keeps dispatch/miss statistics.
// Latency: accept to m_valid is 1 cycle. pop is blocked while the registered count is 2, with no path from m_ready.
module request_dispatcher #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int DATA_WIDTH       = 64,
    parameter int REGISTER_SIZE    = 32
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      valid,
    input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]       selection,
    input  logic [NUMBER_OF_QUEUES-1:0]               empty,
    input  logic [NUMBER_OF_QUEUES*DATA_WIDTH-1:0]    queue_data,
    output logic [NUMBER_OF_QUEUES-1:0]               pop,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [DATA_WIDTH-1:0]                     m_data,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]       m_queue,
    output logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] dispatched,
    output logic [REGISTER_SIZE-1:0]                  missed
);
    localparam int SEL_W = $clog2(NUMBER_OF_QUEUES);

    logic [1:0]               count_q, count_d;
    logic                     head_q, head_d;
    logic [DATA_WIDTH-1:0]    buf_dat_q [2];
    logic [DATA_WIDTH-1:0]    buf_dat_d [2];
    logic [SEL_W-1:0]         buf_que_q [2];
    logic [SEL_W-1:0]         buf_que_d [2];
    logic [REGISTER_SIZE-1:0] dispatched_q [NUMBER_OF_QUEUES];
    logic [REGISTER_SIZE-1:0] dispatched_d [NUMBER_OF_QUEUES];
    logic [REGISTER_SIZE-1:0] missed_q, missed_d;

    logic                  sel_ok;
    logic                  sel_empty;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic                  accept;
    logic                  drain;
    logic                  tail;

    // Selection decode by search, so an out-of-range index simply matches nothing.
    always_comb begin
        sel_ok    = 1'b0;
        sel_empty = 1'b1;
        sel_dat   = '0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (SEL_W'(i) == selection) begin
                sel_ok    = 1'b1;
                sel_empty = empty[i];
                sel_dat   = queue_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // count_q[1] is the registered full flag; reset gating keeps pop quiet while held.
    assign accept  = reset & valid & sel_ok & ~sel_empty & ~count_q[1];
    assign m_valid = (count_q != 2'd0);
    assign drain   = m_valid & m_ready;
    assign tail    = head_q ^ count_q[0];
    assign m_data  = buf_dat_q[head_q];
    assign m_queue = buf_que_q[head_q];
    assign missed  = missed_q;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            pop[i] = accept & (SEL_W'(i) == selection);
        end
    end

    always_comb begin
        count_d   = count_q;
        head_d    = head_q;
        buf_dat_d = buf_dat_q;
        buf_que_d = buf_que_q;
        unique case ({accept, drain})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Draining the last entry leaves head in place so m_data keeps the last request.
        if (drain && !(count_q == 2'd1 && !accept)) begin
            head_d = ~head_q;
        end
        if (accept) begin
            buf_dat_d[tail] = sel_dat;
            buf_que_d[tail] = selection;
        end
    end

    always_comb begin
        dispatched_d = dispatched_q;
        missed_d     = missed_q;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (pop[i]) begin
                dispatched_d[i] = dispatched_q[i] + REGISTER_SIZE'(1);
            end
        end
        if (valid && !accept) begin
            missed_d = missed_q + REGISTER_SIZE'(1);
        end
    end

    always_comb begin
        dispatched = '0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            dispatched[i*REGISTER_SIZE +: REGISTER_SIZE] = dispatched_q[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            head_q    <= 1'b0;
            buf_dat_q <= '{default: '0};
            buf_que_q <= '{default: '0};
            dispatched_q <= '{default: '0};
            missed_q  <= '0;
        end else begin
            count_q   <= count_d;
            head_q    <= head_d;
            buf_dat_q <= buf_dat_d;
            buf_que_q <= buf_que_d;
            dispatched_q <= dispatched_d;
            missed_q  <= missed_d;
        end
    end
endmodule
